// File: rtl/simplebus_pkg.sv
// Shared SimpleBus command encodings, channel payload types and responder FSM states.
package simplebus_pkg;

  localparam logic [3:0] CMD_READ        = 4'b0000;
  localparam logic [3:0] CMD_WRITE       = 4'b0001;
  localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
  localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
  localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
  localparam logic [3:0] CMD_READ_LAST   = 4'b0110;
  localparam logic [3:0] CMD_WRITE_RESP  = 4'b0101;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  cmd;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [15:0] user;
  } simplebus_req_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [63:0] rdata;
    logic [15:0] user;
  } simplebus_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_RD_DATA,
    ST_WR_BURST,
    ST_WR_RESP
  } state_t;

  function automatic logic is_write_cmd(input logic [3:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_BURST) || (cmd == CMD_WRITE_LAST);
  endfunction

  function automatic logic is_read_cmd(input logic [3:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_READ_BURST);
  endfunction

endpackage

// File: rtl/simplebus_mem_array.sv
// 64-bit word store with per-byte synchronous write enables and asynchronous read.
module simplebus_mem_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wmask,
  input  logic [63:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  // One independent byte lane per mask bit keeps the write enable trivially per-byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
      if (we && wmask[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/simplebus_mem_responder.sv
// SimpleBus memory-side responder: single/burst reads and writes with a fixed response latency.
module simplebus_mem_responder
  import simplebus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 12,
  parameter int BURST_BEATS = 8,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_ready,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_bits_addr,
  input  logic [2:0]        req_bits_size,
  input  logic [3:0]        req_bits_cmd,
  input  logic [7:0]        req_bits_wmask,
  input  logic [63:0]       req_bits_wdata,
  input  logic [15:0]       req_bits_user,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [3:0]        resp_bits_cmd,
  output logic [63:0]       resp_bits_rdata,
  output logic [15:0]       resp_bits_user,
  output logic              err_unsupported
);

  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
  localparam logic [DEPTH_LOG2-1:0] BEAT_MASK = DEPTH_LOG2'(BURST_BEATS - 1);
  localparam logic [3:0]            LAT_INIT  = 4'(LATENCY - 1);

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] idx_reg, idx_next;
  logic [15:0]           user_reg, user_next;
  logic [3:0]            cmd_reg, cmd_next;
  logic [3:0]            lat_reg, lat_next;
  logic [BEAT_W-1:0]     beat_reg, beat_next;
  simplebus_resp_t       resp_reg, resp_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  err_reg, err_next;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr, mem_raddr;
  logic [63:0]           mem_rdata;

  logic [DEPTH_LOG2-1:0] req_idx, wrap_idx;
  logic                  accept, resp_fire, rd_is_burst;

  logic unused_req_bits;
  assign unused_req_bits = ^{req_bits_size, req_bits_addr[ADDR_W-1:DEPTH_LOG2+3], req_bits_addr[2:0]};

  assign req_idx     = req_bits_addr[DEPTH_LOG2+2:3];
  // Critical-word-first: only the in-line beat bits advance, the line bits hold.
  assign wrap_idx    = (idx_reg & ~BEAT_MASK) | ((idx_reg + 1'b1) & BEAT_MASK);
  assign accept      = req_valid && req_ready_reg;
  assign resp_fire   = resp_valid_reg && resp_ready;
  assign rd_is_burst = (cmd_reg == CMD_READ_BURST);

  simplebus_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wmask (req_bits_wmask),
    .wdata (req_bits_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      user_reg       <= '0;
      cmd_reg        <= '0;
      lat_reg        <= '0;
      beat_reg       <= '0;
      resp_reg       <= '0;
      resp_valid_reg <= 1'b0;
      req_ready_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      user_reg       <= user_next;
      cmd_reg        <= cmd_next;
      lat_reg        <= lat_next;
      beat_reg       <= beat_next;
      resp_reg       <= resp_next;
      resp_valid_reg <= resp_valid_next;
      req_ready_reg  <= req_ready_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    user_next       = user_reg;
    cmd_next        = cmd_reg;
    lat_next        = lat_reg;
    beat_next       = beat_reg;
    resp_next       = resp_reg;
    resp_valid_next = resp_valid_reg;
    err_next        = err_reg;
    mem_we          = 1'b0;
    mem_waddr       = req_idx;
    mem_raddr       = idx_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          idx_next   = req_idx;
          user_next  = req_bits_user;
          cmd_next   = req_bits_cmd;
          lat_next   = LAT_INIT;
          state_next = ST_LAT;
          case (req_bits_cmd)
            CMD_READ, CMD_READ_BURST: ;
            CMD_WRITE, CMD_WRITE_LAST: mem_we = 1'b1;
            CMD_WRITE_BURST: begin
              mem_we     = 1'b1;
              state_next = ST_WR_BURST;
            end
            default: err_next = 1'b1;
          endcase
        end
      end

      ST_WR_BURST: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = wrap_idx;
          idx_next  = wrap_idx;
          if (req_bits_cmd != CMD_WRITE_BURST) begin
            state_next = ST_LAT;
            lat_next   = LAT_INIT;
            if (req_bits_cmd != CMD_WRITE_LAST) err_next = 1'b1;
          end
        end
      end

      ST_LAT: begin
        if (lat_reg == 4'd0) begin
          resp_valid_next = 1'b1;
          beat_next       = '0;
          resp_next.user  = user_reg;
          if (is_write_cmd(cmd_reg)) begin
            state_next      = ST_WR_RESP;
            resp_next.cmd   = CMD_WRITE_RESP;
            resp_next.rdata = '0;
          end else begin
            // Unsupported commands answer as a single zero-data read beat.
            state_next      = ST_RD_DATA;
            resp_next.cmd   = (rd_is_burst && BURST_BEATS > 1) ? CMD_READ : CMD_READ_LAST;
            resp_next.rdata = is_read_cmd(cmd_reg) ? mem_rdata : '0;
          end
        end else begin
          lat_next = lat_reg - 4'd1;
        end
      end

      ST_RD_DATA: begin
        if (resp_fire) begin
          if (!rd_is_burst || beat_reg == LAST_BEAT) begin
            state_next      = ST_IDLE;
            resp_valid_next = 1'b0;
          end else begin
            mem_raddr       = wrap_idx;
            idx_next        = wrap_idx;
            beat_next       = beat_reg + 1'b1;
            resp_next.rdata = mem_rdata;
            resp_next.cmd   = (beat_next == LAST_BEAT) ? CMD_READ_LAST : CMD_READ;
          end
        end
      end

      ST_WR_RESP: begin
        if (resp_fire) begin
          state_next      = ST_IDLE;
          resp_valid_next = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Registered so it is low throughout reset and never follows req_valid.
  assign req_ready_next = (state_next == ST_IDLE) || (state_next == ST_WR_BURST);

  assign req_ready       = req_ready_reg;
  assign resp_valid      = resp_valid_reg;
  assign resp_bits_cmd   = resp_reg.cmd;
  assign resp_bits_rdata = resp_reg.rdata;
  assign resp_bits_user  = resp_reg.user;
  assign err_unsupported = err_reg;

endmodule

// File: tb/tb_simplebus_mem_responder.sv
// Table-driven bench with a response scoreboard for simplebus_mem_responder.
module tb_simplebus_mem_responder;
  import simplebus_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ready, req_valid;
  logic [31:0] req_bits_addr;
  logic [2:0]  req_bits_size;
  logic [3:0]  req_bits_cmd;
  logic [7:0]  req_bits_wmask;
  logic [63:0] req_bits_wdata;
  logic [15:0] req_bits_user;
  logic        resp_ready, resp_valid;
  logic [3:0]  resp_bits_cmd;
  logic [63:0] resp_bits_rdata;
  logic [15:0] resp_bits_user;
  logic        err_unsupported;

  always #5 clk = ~clk;

  simplebus_mem_responder #(
    .ADDR_W(32), .DEPTH_LOG2(12), .BURST_BEATS(8), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_ready(req_ready), .req_valid(req_valid),
    .req_bits_addr(req_bits_addr), .req_bits_size(req_bits_size),
    .req_bits_cmd(req_bits_cmd), .req_bits_wmask(req_bits_wmask),
    .req_bits_wdata(req_bits_wdata), .req_bits_user(req_bits_user),
    .resp_ready(resp_ready), .resp_valid(resp_valid),
    .resp_bits_cmd(resp_bits_cmd), .resp_bits_rdata(resp_bits_rdata),
    .resp_bits_user(resp_bits_user), .err_unsupported(err_unsupported)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [15:0] user;
    logic [3:0]  exp_cmd;
    logic [63:0] exp_rdata;
    bit          chk_lat;
  } vec_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [63:0] rdata;
    logic [15:0] user;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   beats_seen = 0;
  int   stall_at = -1;
  int   stall_left = 0;
  bit   pending_stall = 0;
  bit   held_v = 0;
  logic [83:0] held;

  always @(posedge clk) cyc++;

  task automatic record(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    record(act === exp, name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [3:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input logic [15:0] user, input logic [3:0] exp_cmd,
                               input logic [63:0] exp_rdata, input bit chk_lat);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.wmask = wmask; v.user = user;
    v.exp_cmd = exp_cmd; v.exp_rdata = exp_rdata; v.chk_lat = chk_lat;
    return v;
  endfunction

  task automatic push_exp(input logic [3:0] cmd, input logic [63:0] rdata, input logic [15:0] user);
    exp_t e;
    e.cmd = cmd; e.rdata = rdata; e.user = user;
    sb.push_back(e);
  endtask

  // Drive one request beat; returns #1 after the accepting edge.
  task automatic send_beat(input logic [3:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input logic [15:0] user);
    int n = 0;
    req_valid = 1'b1; req_bits_cmd = cmd; req_bits_addr = addr; req_bits_wdata = wdata;
    req_bits_wmask = wmask; req_bits_user = user; req_bits_size = 3'd3;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) record(1'b0, "req_ready_timeout", 96'(n), 96'(50));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 96'(sb.size()), 96'(0));
    @(negedge clk);
  endtask

  // Response monitor, scoreboard pop and backpressure generator.
  always @(negedge clk) begin
    logic [83:0] cur;
    exp_t e;
    cur = {resp_bits_cmd, resp_bits_rdata, resp_bits_user};
    if (pending_stall) begin
      pending_stall = 0;
      resp_ready = 1'b0;
      stall_left = 5;
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) resp_ready = 1'b1;
    end
    if (rst && resp_valid && !resp_ready) begin
      if (held_v) check("stall_stable", 96'(cur), 96'(held));
      held = cur;
      held_v = 1;
    end else begin
      held_v = 0;
    end
    if (rst && resp_valid && resp_ready) begin
      record(sb.size() != 0, "beat_expected", 96'(sb.size()), 96'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_beat", 96'(cur), 96'({e.cmd, e.rdata, e.user}));
        $display("beat %0d: cmd=%h rdata=%h user=%h", beats_seen, resp_bits_cmd, resp_bits_rdata, resp_bits_user);
      end
      beats_seen++;
      if (beats_seen == stall_at) pending_stall = 1;
    end
  end

  initial begin
    int n;
    rst = 1'b0; req_valid = 1'b0; req_bits_addr = '0; req_bits_size = '0; req_bits_cmd = '0;
    req_bits_wmask = '0; req_bits_wdata = '0; req_bits_user = '0; resp_ready = 1'b1;

    vecs[0]  = mkv(CMD_WRITE,      32'h100,  64'h1122334455667788, 8'hFF, 16'h00A5, CMD_WRITE_RESP, 64'h0, 1);
    vecs[1]  = mkv(CMD_READ,       32'h100,  64'h0,                8'h00, 16'h0001, CMD_READ_LAST,  64'h1122334455667788, 1);
    vecs[2]  = mkv(CMD_WRITE,      32'h100,  64'hFFFFFFFFFFFFFFFF, 8'h0F, 16'h0002, CMD_WRITE_RESP, 64'h0, 0);
    vecs[3]  = mkv(CMD_READ,       32'h100,  64'h0,                8'h00, 16'h0003, CMD_READ_LAST,  64'h11223344FFFFFFFF, 0);
    vecs[4]  = mkv(CMD_WRITE,      32'h108,  64'hA5A5A5A55A5A5A5A, 8'hFF, 16'h0004, CMD_WRITE_RESP, 64'h0, 0);
    vecs[5]  = mkv(CMD_WRITE,      32'h108,  64'h0,                8'h00, 16'h0005, CMD_WRITE_RESP, 64'h0, 0);
    vecs[6]  = mkv(CMD_READ,       32'h108,  64'h0,                8'h00, 16'h0006, CMD_READ_LAST,  64'hA5A5A5A55A5A5A5A, 0);
    vecs[7]  = mkv(CMD_WRITE_LAST, 32'h110,  64'h0123456789ABCDEF, 8'hFF, 16'h0007, CMD_WRITE_RESP, 64'h0, 0);
    vecs[8]  = mkv(CMD_READ,       32'h8110, 64'h0,                8'h00, 16'h0008, CMD_READ_LAST,  64'h0123456789ABCDEF, 0);
    vecs[9]  = mkv(4'h8,           32'h0,    64'h0,                8'h00, 16'h1234, CMD_READ_LAST,  64'h0, 0);
    vecs[10] = mkv(CMD_READ,       32'h100,  64'h0,                8'h00, 16'h00AA, CMD_READ_LAST,  64'h11223344FFFFFFFF, 0);

    // Reset held for three cycles, outputs must be quiet.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 96'(req_ready), 96'(0));
    check("rst_resp_valid", 96'(resp_valid), 96'(0));
    check("rst_resp_bits", 96'({resp_bits_cmd, resp_bits_rdata, resp_bits_user}), 96'(0));
    check("rst_err", 96'(err_unsupported), 96'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", 96'(req_ready), 96'(1));
    check("err_after_rst", 96'(err_unsupported), 96'(0));

    for (int i = 0; i < 11; i++) begin
      push_exp(vecs[i].exp_cmd, vecs[i].exp_rdata, vecs[i].user);
      send_beat(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].user);
      if (vecs[i].chk_lat) begin
        n = 0;
        while (!resp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("latency", 96'(cyc - acc_cyc), 96'(LAT));
      end
      wait_drain();
      $display("vec %0d: cmd=%h addr=%h done", i, vecs[i].cmd, vecs[i].addr);
    end
    check("err_sticky", 96'(err_unsupported), 96'(1));

    // Burst write of k into beat k starting at 0x200.
    push_exp(CMD_WRITE_RESP, 64'h0, 16'h0C0C);
    for (int k = 0; k < 8; k++)
      send_beat((k < 7) ? CMD_WRITE_BURST : CMD_WRITE_LAST, 32'h200 + 32'(k * 8), 64'(k), 8'hFF, 16'h0C0C);
    wait_drain();

    // Wrapped burst read from 0x218 with a 5-cycle stall on beat 3.
    beats_seen = 0;
    stall_at = 3;
    for (int k = 0; k < 8; k++)
      push_exp((k < 7) ? CMD_READ : CMD_READ_LAST, 64'((k + 3) % 8), 16'h0BB0);
    send_beat(CMD_READ_BURST, 32'h218, 64'h0, 8'h00, 16'h0BB0);
    wait_drain();
    stall_at = -1;
    check("burst_beat_count", 96'(beats_seen), 96'(8));
    repeat (4) @(negedge clk);
    check("no_extra_beat", 96'(resp_valid), 96'(0));

    // Back-to-back burst read from line start.
    beats_seen = 0;
    for (int k = 0; k < 8; k++)
      push_exp((k < 7) ? CMD_READ : CMD_READ_LAST, 64'(k), 16'h0DD0);
    send_beat(CMD_READ_BURST, 32'h200, 64'h0, 8'h00, 16'h0DD0);
    wait_drain();
    check("burst2_beat_count", 96'(beats_seen), 96'(8));
    check("err_still_sticky", 96'(err_unsupported), 96'(1));

    // Reset clears the sticky error.
    rst = 1'b0;
    @(negedge clk);
    check("rst2_err", 96'(err_unsupported), 96'(0));
    check("rst2_req_ready", 96'(req_ready), 96'(0));
    rst = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst2", 96'(req_ready), 96'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
